// File: rtl/sic_issue_dispatch.sv
// SIC issue dispatch: queues decoded packets and hands each one to a single idle sub-SIC slot.
// Optional statistics counters are enabled with `define SIC_DISPATCH_STATS_EN.
package sic_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } sic_packet_t;
endpackage

module sic_issue_dispatch
    import sic_pkg::*;
#(
    parameter int NUM_SLOTS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  sic_packet_t                   in_pkt,
    input  logic                          flush,
    input  logic [NUM_SLOTS-1:0]          slot_req,
    output sic_packet_t [NUM_SLOTS-1:0]   slot_pkt,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
`ifdef SIC_DISPATCH_STATS_EN
    ,
    output logic [31:0]                   stat_issued,
    output logic [31:0]                   stat_stall
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    sic_packet_t                 mem_q [FIFO_DEPTH];
    sic_packet_t                 mem_d [FIFO_DEPTH];
    logic [AW:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW:0]                 rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]               rr_q, rr_d;
    sic_packet_t [NUM_SLOTS-1:0] slot_pkt_q, slot_pkt_d;
    logic [NUM_SLOTS-1:0]        sent_last_q, sent_last_d;
    logic [NUM_SLOTS-1:0]        slot_valid, eligible;
    logic                        full, empty, push, found, grant;
    logic [RW-1:0]               grant_idx;
    sic_packet_t                 head;
    int                          idx;
`ifdef SIC_DISPATCH_STATS_EN
    logic [31:0]                 stat_issued_q, stat_issued_d;
    logic [31:0]                 stat_stall_q, stat_stall_d;
`endif

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        in_ready = !full && !flush && !rst;
        push     = in_valid && in_ready;
        head     = mem_q[rd_ptr_q[AW-1:0]];

        // A slot just served stays ineligible for two cycles so a late busy indication cannot double-issue.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_valid[i] = slot_pkt_q[i].valid;
        end
        eligible = slot_req & ~slot_valid & ~sent_last_q;

        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx = (int'(rr_q) + k) % NUM_SLOTS;
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = RW'(idx);
            end
        end
        grant = found && !empty && !flush;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_pkt;
        end

        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(grant);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        rr_d = rr_q;
        if (grant) begin
            rr_d = (int'(grant_idx) == NUM_SLOTS - 1) ? '0 : grant_idx + RW'(1);
        end

        slot_pkt_d = '0;
        if (grant) begin
            slot_pkt_d[grant_idx]       = head;
            slot_pkt_d[grant_idx].valid = 1'b1;
        end
        sent_last_d = slot_valid;

`ifdef SIC_DISPATCH_STATS_EN
        stat_issued_d = stat_issued_q + 32'(grant);
        stat_stall_d  = stat_stall_q + 32'(!empty && (eligible == '0));
`endif
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rr_q        <= '0;
            slot_pkt_q  <= '0;
            sent_last_q <= '0;
`ifdef SIC_DISPATCH_STATS_EN
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rr_q        <= rr_d;
            slot_pkt_q  <= slot_pkt_d;
            sent_last_q <= sent_last_d;
`ifdef SIC_DISPATCH_STATS_EN
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
`endif
        end
    end

    assign slot_pkt  = slot_pkt_q;
    assign occupancy = wr_ptr_q - rd_ptr_q;
`ifdef SIC_DISPATCH_STATS_EN
    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif
endmodule

// File: tb/tb_sic_issue_dispatch.sv
// Directed testbench for sic_issue_dispatch; deliveries are checked against a queue of expected (slot, pc).
// Statistics checks are compiled in when SIC_DISPATCH_STATS_EN is defined.
module tb_sic_issue_dispatch;
    import sic_pkg::*;

    localparam int NUM_SLOTS  = 4;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        int          slot;
        logic [31:0] pc;
    } expect_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        in_valid;
    logic                        in_ready;
    sic_packet_t                 in_pkt;
    logic                        flush;
    logic [NUM_SLOTS-1:0]        slot_req;
    sic_packet_t [NUM_SLOTS-1:0] slot_pkt;
    logic [2:0]                  occupancy;
`ifdef SIC_DISPATCH_STATS_EN
    logic [31:0]                 stat_issued;
    logic [31:0]                 stat_stall;
`endif

    int      checks     = 0;
    int      failures   = 0;
    int      cyc        = 0;
    int      deliveries = 0;
    int      snap;
    int      last_del [NUM_SLOTS];
    expect_t sb [$];

    sic_issue_dispatch #(.NUM_SLOTS(NUM_SLOTS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
        .flush(flush), .slot_req(slot_req), .slot_pkt(slot_pkt), .occupancy(occupancy)
`ifdef SIC_DISPATCH_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Delivery monitor: every valid pulse must match the scoreboard head and respect the re-issue gap.
    initial for (int i = 0; i < NUM_SLOTS; i++) last_del[i] = -100;
    always @(negedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_pkt[i].valid === 1'b1) begin
                deliveries++;
                checks++;
                assert (sb.size() !== 0) else begin
                    failures++;
                    $error("[TB] FAIL unexpected_delivery slot=%0d pc=%0h observed with no expectation", i, slot_pkt[i].pc);
                end
                if (sb.size() != 0) begin
                    expect_t e;
                    e = sb.pop_front();
                    checks++;
                    assert ((i === e.slot) && (slot_pkt[i].pc === e.pc)) else begin
                        failures++;
                        $error("[TB] FAIL delivery observed slot=%0d pc=%0h expected slot=%0d pc=%0h", i, slot_pkt[i].pc, e.slot, e.pc);
                    end
                end
                checks++;
                assert ((cyc - last_del[i]) >= 3) else begin
                    failures++;
                    $error("[TB] FAIL reissue_gap slot=%0d observed gap=%0d expected >=3", i, cyc - last_del[i]);
                end
                last_del[i] = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic fl, input logic [NUM_SLOTS-1:0] req);
        in_valid     = v;
        in_pkt       = '0;
        in_pkt.pc    = pc;
        in_pkt.instr = ~pc;
        flush        = fl;
        slot_req     = req;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expectPkt(input int slot, input logic [31:0] pc);
        expect_t e;
        e.slot = slot;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_timeout", 512'(sb.size()), 512'(0));
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, '0);
        repeat (3) tick();
        checkOutput("reset_slot_pkt", 512'(slot_pkt), 512'(0));
        checkOutput("reset_occupancy", 512'(occupancy), 512'(0));
        checkOutput("reset_in_ready", 512'(in_ready), 512'(0));
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 512'(in_ready), 512'(1));

        $display("[TB] in-order delivery to slots 0,1,2");
        expectPkt(0, 32'h100); expectPkt(1, 32'h104); expectPkt(2, 32'h108);
        applyStimulus(1'b1, 32'h100, 1'b0, 4'hF);
        tick();
        checkOutput("no_bypass_valid", 512'(slot_pkt[0].valid), 512'(0));
        checkOutput("occ_after_first_push", 512'(occupancy), 512'(1));
        applyStimulus(1'b1, 32'h104, 1'b0, 4'hF);
        tick();
        applyStimulus(1'b1, 32'h108, 1'b0, 4'hF);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'hF);
        waitDrain(20);

        $display("[TB] slot 2 holds request after delivery");
        expectPkt(2, 32'h200); expectPkt(2, 32'h204);
        applyStimulus(1'b1, 32'h200, 1'b0, 4'b0100);
        tick();
        applyStimulus(1'b1, 32'h204, 1'b0, 4'b0100);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0100);
        waitDrain(20);

        $display("[TB] fill queue then drain through slot 3");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4 * k), 1'b0, 4'b0000);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000);
        #1;
        checkOutput("full_in_ready", 512'(in_ready), 512'(0));
        checkOutput("full_occupancy", 512'(occupancy), 512'(4));
        for (int k = 0; k < 4; k++) expectPkt(3, 32'h300 + 32'(4 * k));
        applyStimulus(1'b1, 32'h3FF, 1'b0, 4'b1000);
        #1;
        checkOutput("full_pop_cycle_ready", 512'(in_ready), 512'(0));
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b1000);
        #1;
        checkOutput("after_pop_occupancy", 512'(occupancy), 512'(3));
        checkOutput("after_pop_ready", 512'(in_ready), 512'(1));
        waitDrain(40);

        $display("[TB] flush with simultaneous push");
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h400 + 32'(4 * k), 1'b0, 4'b0000);
            tick();
        end
        applyStimulus(1'b1, 32'h4FF, 1'b1, 4'b0000);
        #1;
        checkOutput("flush_in_ready", 512'(in_ready), 512'(0));
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'hF);
        #1;
        checkOutput("flush_occupancy", 512'(occupancy), 512'(0));
        snap = deliveries;
        repeat (8) tick();
        checkOutput("flush_no_delivery", 512'(deliveries), 512'(snap));

        $display("[TB] reset during delivery");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h500 + 32'(4 * k), 1'b0, 4'b0000);
            tick();
        end
        expectPkt(1, 32'h500);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0010);
        tick();
        checkOutput("pre_reset_valid1", 512'(slot_pkt[1].valid), 512'(1));
        checkOutput("pre_reset_occupancy", 512'(occupancy), 512'(2));
        rst = 1'b1;
        tick();
        checkOutput("mid_reset_slot_pkt", 512'(slot_pkt), 512'(0));
        checkOutput("mid_reset_occupancy", 512'(occupancy), 512'(0));
        rst = 1'b0;
        snap = deliveries;
        repeat (6) tick();
        checkOutput("reset_discard", 512'(deliveries), 512'(snap));
        expectPkt(0, 32'h600);
        applyStimulus(1'b1, 32'h600, 1'b0, 4'hF);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'hF);
        waitDrain(20);

`ifdef SIC_DISPATCH_STATS_EN
        $display("[TB] statistics counters");
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000);
        tick();
        rst = 1'b0;
        checkOutput("stat_reset_issued", 512'(stat_issued), 512'(0));
        checkOutput("stat_reset_stall", 512'(stat_stall), 512'(0));
        expectPkt(0, 32'h700); expectPkt(1, 32'h704); expectPkt(2, 32'h708);
        expectPkt(3, 32'h70C); expectPkt(0, 32'h710);
        applyStimulus(1'b1, 32'h700, 1'b0, 4'b0000);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000);
        repeat (3) tick();
        for (int k = 1; k < 5; k++) begin
            applyStimulus(1'b1, 32'h700 + 32'(4 * k), 1'b0, 4'hF);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 4'hF);
        waitDrain(20);
        checkOutput("stat_issued", 512'(stat_issued), 512'(5));
        checkOutput("stat_stall", 512'(stat_stall), 512'(3));
        applyStimulus(1'b0, 32'h0, 1'b1, 4'hF);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'hF);
        tick();
        checkOutput("stat_issued_flush", 512'(stat_issued), 512'(5));
        checkOutput("stat_stall_flush", 512'(stat_stall), 512'(3));
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
